// File: rtl/cordic_pkg.sv
// ----------------------------------------------------------------------------
// cordic_pkg
//   Shared constants for the CORDIC datapath channel steering blocks.
//   - CH_0 / CH_1 : channel index values carried on a 1-bit select.
//   - CNT_W       : width of the optional per-channel word counters.
//   - EMPTY/FULL  : one-entry output buffer state encoding.
//   - sat_inc     : saturating increment used by the word counters.
// ----------------------------------------------------------------------------
package cordic_pkg;

    localparam logic CH_0  = 1'b0;
    localparam logic CH_1  = 1'b1;

    localparam int   CNT_W = 16;

    // Buffer state encoding; the state bit doubles as the valid flag.
    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] w_next;
        w_next = (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
        return w_next;
    endfunction

endpackage

// File: rtl/demux_out_buf.sv
// ----------------------------------------------------------------------------
// demux_out_buf
//   One-entry registered output buffer for a single demux channel.
//   Loads a word when the parent accepts a word for this channel, drains
//   when the consumer takes it, and supports drain + reload in one cycle
//   for full throughput.
//
//   Optional feature macro: DEMUX_1X2_BUF_CNT_EN
//     When defined, o_cnt counts loaded words and saturates at all-ones.
//
//   Ports:
//     clk      in   system clock, rising edge
//     rst      in   asynchronous active-high reset
//     i_load   in   parent accepted a word for this channel this cycle
//     i_data   in   word to load
//     i_ready  in   consumer accepts the buffered word
//     o_space  out  buffer can take a word this cycle (empty or draining)
//     o_valid  out  buffer holds a word
//     o_data   out  buffered word (holds last value after draining)
//     o_cnt    out  (macro only) saturating count of loaded words
// ----------------------------------------------------------------------------
module demux_out_buf
    import cordic_pkg::*;
#(
    parameter int W = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [W-1:0]     i_data,
    input  logic             i_ready,
    output logic             o_space,
    output logic             o_valid,
`ifdef DEMUX_1X2_BUF_CNT_EN
    output logic [CNT_W-1:0] o_cnt,
`endif
    output logic [W-1:0]     o_data
);

    logic         r_state;
    logic [W-1:0] r_data;
    logic         w_drain;

    assign w_drain = (r_state == FULL) && i_ready;

    // A full buffer that is draining this cycle can accept a replacement,
    // which is what gives one word per cycle per channel.
    assign o_space = (r_state == EMPTY) || i_ready;

    // i_load is only raised by the parent while o_space is high, so a load
    // never overwrites a word the consumer has not taken.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    // NOTE: the data register is reset too because the reset value of the
    // output word is defined as zero, not left unknown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_data  <= '0;
        end else if (i_load) begin
            r_state <= FULL;
            r_data  <= i_data;
        end else if (w_drain) begin
            r_state <= EMPTY;
        end
    end

    assign o_valid = r_state;
    assign o_data  = r_data;

`ifdef DEMUX_1X2_BUF_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= sat_inc(r_cnt);
        end
    end

    assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/demux_1x2_buf.sv
// ----------------------------------------------------------------------------
// demux_1x2_buf
//   Registered 1-to-2 demultiplexer with valid/ready handshakes. Each word
//   from the producer is steered by `select` into one of two independent
//   one-entry output buffers, so a stalled channel never blocks the other.
//
//   Optional feature macro: DEMUX_1X2_BUF_CNT_EN
//     When defined, adds cnt_0 / cnt_1: saturating counts of words accepted
//     into each channel.
//
//   Ports:
//     clk          in   system clock, rising edge
//     rst          in   asynchronous active-high reset
//     in_valid     in   producer presents a word
//     in_ready     out  selected channel can take the word (combinational)
//     select       in   destination channel, meaningful while in_valid
//     data_in      in   input word
//     out_valid_0  out  channel 0 holds a word
//     out_ready_0  in   channel 0 consumer accepts
//     data_out_0   out  channel 0 word
//     out_valid_1  out  channel 1 holds a word
//     out_ready_1  in   channel 1 consumer accepts
//     data_out_1   out  channel 1 word
//     cnt_0/cnt_1  out  (macro only) per-channel accepted-word counters
// ----------------------------------------------------------------------------
module demux_1x2_buf
    import cordic_pkg::*;
#(
    parameter int W = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             select,
    input  logic [W-1:0]     data_in,
    output logic             out_valid_0,
    input  logic             out_ready_0,
    output logic [W-1:0]     data_out_0,
    output logic             out_valid_1,
    input  logic             out_ready_1,
`ifdef DEMUX_1X2_BUF_CNT_EN
    output logic [CNT_W-1:0] cnt_0,
    output logic [CNT_W-1:0] cnt_1,
`endif
    output logic [W-1:0]     data_out_1
);

    logic w_space_0;
    logic w_space_1;
    logic w_acc;
    logic w_load_0;
    logic w_load_1;

    // Readiness looks only at the selected channel; the other channel's
    // stall state is irrelevant to this transfer.
    assign in_ready = (select == CH_1) ? w_space_1 : w_space_0;
    assign w_acc    = in_valid && in_ready;
    assign w_load_0 = w_acc && (select == CH_0);
    assign w_load_1 = w_acc && (select == CH_1);

    demux_out_buf #(.W(W)) u_buf_0 (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load_0),
        .i_data  (data_in),
        .i_ready (out_ready_0),
        .o_space (w_space_0),
        .o_valid (out_valid_0),
`ifdef DEMUX_1X2_BUF_CNT_EN
        .o_cnt   (cnt_0),
`endif
        .o_data  (data_out_0)
    );

    demux_out_buf #(.W(W)) u_buf_1 (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load_1),
        .i_data  (data_in),
        .i_ready (out_ready_1),
        .o_space (w_space_1),
        .o_valid (out_valid_1),
`ifdef DEMUX_1X2_BUF_CNT_EN
        .o_cnt   (cnt_1),
`endif
        .o_data  (data_out_1)
    );

endmodule

// File: tb/tb_demux_1x2_buf.sv
// ----------------------------------------------------------------------------
// tb_demux_1x2_buf
//   Self-checking bench for demux_1x2_buf. A queue-based reference model
//   (one capacity-1 FIFO per channel) predicts outputs; a compare process
//   checks every falling edge, and directed sequences pin literal values.
//   Optional macro DEMUX_1X2_BUF_CNT_EN enables counter checks.
// ----------------------------------------------------------------------------
module tb_demux_1x2_buf;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         select;
    logic [W-1:0] data_in;
    logic         out_valid_0;
    logic         out_ready_0;
    logic [W-1:0] data_out_0;
    logic         out_valid_1;
    logic         out_ready_1;
    logic [W-1:0] data_out_1;
`ifdef DEMUX_1X2_BUF_CNT_EN
    logic [15:0]  cnt_0;
    logic [15:0]  cnt_1;
`endif

    demux_1x2_buf #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .select      (select),
        .data_in     (data_in),
        .out_valid_0 (out_valid_0),
        .out_ready_0 (out_ready_0),
        .data_out_0  (data_out_0),
        .out_valid_1 (out_valid_1),
        .out_ready_1 (out_ready_1),
`ifdef DEMUX_1X2_BUF_CNT_EN
        .cnt_0       (cnt_0),
        .cnt_1       (cnt_1),
`endif
        .data_out_1  (data_out_1)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel is a FIFO of capacity one. A word enters if the FIFO is
    // empty or its head is being taken by the consumer in the same cycle.
    logic [W-1:0] m_q0[$];
    logic [W-1:0] m_q1[$];
    logic [W-1:0] m_last0 = '0;
    logic [W-1:0] m_last1 = '0;
    int           m_cnt0  = 0;
    int           m_cnt1  = 0;

    function automatic bit m_room(input bit ch);
        if (ch) return (m_q1.size() == 0) || (out_ready_1 === 1'b1);
        return (m_q0.size() == 0) || (out_ready_0 === 1'b1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q0.delete();
            m_q1.delete();
            m_last0 = '0;
            m_last1 = '0;
            m_cnt0  = 0;
            m_cnt1  = 0;
        end else begin
            bit acc;
            acc = (in_valid === 1'b1) && m_room(select);
            if (m_q0.size() > 0 && out_ready_0 === 1'b1) void'(m_q0.pop_front());
            if (m_q1.size() > 0 && out_ready_1 === 1'b1) void'(m_q1.pop_front());
            if (acc) begin
                if (select) begin
                    m_q1.push_back(data_in);
                    m_last1 = data_in;
                    if (m_cnt1 < 65535) m_cnt1++;
                end else begin
                    m_q0.push_back(data_in);
                    m_last0 = data_in;
                    if (m_cnt0 < 65535) m_cnt0++;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("in_ready",    {31'd0, in_ready},    {31'd0, m_room(select)});
        check("out_valid_0", {31'd0, out_valid_0}, {31'd0, m_q0.size() != 0});
        check("out_valid_1", {31'd0, out_valid_1}, {31'd0, m_q1.size() != 0});
        check("data_out_0",  data_out_0, (m_q0.size() != 0) ? m_q0[0] : m_last0);
        check("data_out_1",  data_out_1, (m_q1.size() != 0) ? m_q1[0] : m_last1);
`ifdef DEMUX_1X2_BUF_CNT_EN
        check("cnt_0", {16'd0, cnt_0}, m_cnt0);
        check("cnt_1", {16'd0, cnt_1}, m_cnt1);
`endif
    end

    // An unknown select during a valid transfer is a producer bug.
    always @(posedge clk) begin
        if (in_valid === 1'b1) check("select_known", {31'd0, $isunknown(select)}, 32'd0);
    end

    // Advance one edge; inputs are changed 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit s, input logic [W-1:0] d);
        in_valid = v;
        select   = s;
        data_in  = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        select      = 1'b0;
        data_in     = '0;
        out_ready_0 = 1'b1;
        out_ready_1 = 1'b1;
        step();
        step();
        check("rst_valid_0", {31'd0, out_valid_0}, 32'd0);
        check("rst_valid_1", {31'd0, out_valid_1}, 32'd0);
        check("rst_data_0",  data_out_0, 32'd0);
        check("rst_data_1",  data_out_1, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        step();

        // Basic routing
        drive(1, 0, 32'hA5A5_0001);
        step();
        check("route_data_0",  data_out_0, 32'hA5A5_0001);
        check("route_valid_0", {31'd0, out_valid_0}, 32'd1);
        check("route_valid_1a", {31'd0, out_valid_1}, 32'd0);
        drive(1, 1, 32'h5A5A_0002);
        step();
        check("route_data_1",  data_out_1, 32'h5A5A_0002);
        check("route_valid_1", {31'd0, out_valid_1}, 32'd1);
        check("route_valid_0b", {31'd0, out_valid_0}, 32'd0);
        drive(0, 0, '0);
        step();

        // Stall isolation
        out_ready_0 = 1'b0;
        drive(1, 0, 32'h1);
        step();
        drive(1, 0, 32'h2);
        #1;
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("stall_hold_0", data_out_0, 32'h1);
        check("stall_valid_0", {31'd0, out_valid_0}, 32'd1);
        drive(1, 1, 32'h3);
        #1;
        check("iso_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("iso_data_1", data_out_1, 32'h3);
        check("iso_hold_0", data_out_0, 32'h1);
        drive(0, 0, '0);
        out_ready_0 = 1'b1;
        step();
        step();

        // Back-to-back on channel 1
        out_ready_1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, i);
            #1;
            check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
            step();
            check("b2b_valid_1", {31'd0, out_valid_1}, 32'd1);
            check("b2b_data_1", data_out_1, i);
        end
        drive(0, 0, '0);
        step();
        check("b2b_empty_1", {31'd0, out_valid_1}, 32'd0);
        check("b2b_keep_1",  data_out_1, 32'd7);

        // Simultaneous drain and refill on channel 0
        out_ready_0 = 1'b0;
        drive(1, 0, 32'hDEAD);
        step();
        check("refill_first", data_out_0, 32'hDEAD);
        out_ready_0 = 1'b1;
        drive(1, 0, 32'hBEEF);
        step();
        check("refill_data",  data_out_0, 32'hBEEF);
        check("refill_valid", {31'd0, out_valid_0}, 32'd1);
        drive(0, 0, '0);
        step();

        // Asynchronous reset with both buffers full
        out_ready_0 = 1'b0;
        out_ready_1 = 1'b0;
        drive(1, 0, 32'h11);
        step();
        drive(1, 1, 32'h22);
        step();
        drive(0, 0, '0);
        check("pre_rst_valid_0", {31'd0, out_valid_0}, 32'd1);
        check("pre_rst_valid_1", {31'd0, out_valid_1}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid_0", {31'd0, out_valid_0}, 32'd0);
        check("arst_valid_1", {31'd0, out_valid_1}, 32'd0);
        check("arst_data_0",  data_out_0, 32'd0);
        check("arst_data_1",  data_out_1, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom);
            out_ready_0 = ($urandom_range(0, 3) != 0);
            out_ready_1 = ($urandom_range(0, 3) != 0);
            step();
        end
        drive(0, 0, '0);
        out_ready_0 = 1'b1;
        out_ready_1 = 1'b1;
        step();

`ifdef DEMUX_1X2_BUF_CNT_EN
        // Counter saturation on channel 1
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 65534; i++) begin
            drive(1, 1, i);
            step();
        end
        check("cnt_1_fffe", {16'd0, cnt_1}, 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, i);
            step();
        end
        drive(0, 0, '0);
        step();
        check("cnt_1_sat",  {16'd0, cnt_1}, 32'h0000_FFFF);
        check("cnt_0_zero", {16'd0, cnt_0}, 32'd0);
`endif

        step();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
